// File: rtl/pipeline_flushable_pkg.sv
// Shared types and helpers for the flushable skid-stage pipeline.
package pipeline_flushable_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  // Occupancy width for 0..2*num_stages elements; never narrower than one bit.
  function automatic int count_width(input int num_stages);
    int w;
    w = $clog2(2 * num_stages + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipeline_flushable_stage.sv
// One 2-entry skid stage: main register drives the output, skid absorbs the
// element that arrives in the cycle the downstream stalls. Flush empties it.
module pipeline_flushable_stage
  import pipeline_flushable_pkg::*;
#(
  parameter int ElemWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 flush_i,
  input  logic [ElemWidth-1:0] in_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [ElemWidth-1:0] out_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i
);

  stage_state_e         state_q;
  logic [ElemWidth-1:0] main_q;
  logic [ElemWidth-1:0] skid_q;
  logic                 in_fire;
  logic                 out_fire;

  // Ready is a decode of the state register only, so no ready path crosses the stage.
  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign out_o       = main_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q <= ONE;
            main_q  <= in_i;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_i;
          end else if (in_fire) begin
            state_q <= TWO;
            skid_q  <= in_i;
          end else if (out_fire) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_q <= ONE;
            main_q  <= skid_q;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_flushable.sv
// N-stage valid/ready skid pipeline with synchronous flush.
// Optional occupancy output count_o under PIPELINE_FLUSHABLE_COUNT_EN.
module pipeline_flushable
  import pipeline_flushable_pkg::*;
#(
  parameter int ElemWidth = 8,
  parameter int NumStages = 2,
  localparam int CountW   = count_width(NumStages)
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 flush_i,
  input  logic [ElemWidth-1:0] elem_in_i,
  input  logic                 elem_in_valid_i,
  output logic                 elem_in_ready_o,
  output logic [ElemWidth-1:0] elem_out_o,
  output logic                 elem_out_valid_o,
  input  logic                 elem_out_ready_i
`ifdef PIPELINE_FLUSHABLE_COUNT_EN
  ,
  output logic [CountW-1:0]    count_o
`endif
);

  if (NumStages == 0) begin : g_pass
    assign elem_out_o       = elem_in_i;
    assign elem_out_valid_o = elem_in_valid_i & ~flush_i;
    assign elem_in_ready_o  = elem_out_ready_i | flush_i;
  end else begin : g_chain
    logic [ElemWidth-1:0] data  [NumStages+1];
    logic                 valid [NumStages+1];
    logic                 ready [NumStages+1];

    assign data[0]          = elem_in_i;
    assign valid[0]         = elem_in_valid_i;
    assign ready[NumStages] = elem_out_ready_i;

    for (genvar k = 0; k < NumStages; k++) begin : g_stage
      pipeline_flushable_stage #(.ElemWidth(ElemWidth)) u_stage (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .flush_i     (flush_i),
        .in_i        (data[k]),
        .in_valid_i  (valid[k]),
        .in_ready_o  (ready[k]),
        .out_o       (data[k+1]),
        .out_valid_o (valid[k+1]),
        .out_ready_i (ready[k+1])
      );
    end

    // Flush masks the boundary handshake in the same cycle: nothing leaves,
    // and whatever is offered is swallowed.
    assign elem_out_o       = data[NumStages];
    assign elem_out_valid_o = valid[NumStages] & ~flush_i;
    assign elem_in_ready_o  = ready[0] | flush_i;
  end

`ifdef PIPELINE_FLUSHABLE_COUNT_EN
  if (NumStages == 0) begin : g_cnt_zero
    assign count_o = '0;
  end else begin : g_cnt
    localparam logic [CountW-1:0] Cap = CountW'(2 * NumStages);
    logic [CountW-1:0] count_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = elem_in_valid_i & elem_in_ready_o & ~flush_i;
    assign out_fire = elem_out_valid_o & elem_out_ready_i;

    always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
        count_q <= '0;
      end else if (flush_i) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + CountW'(in_fire) - CountW'(out_fire);
      end
    end

    assign count_o = count_q;

    cap_a: assert property (@(posedge clk_i) disable iff (!arst_ni) count_q <= Cap);
  end
`endif

endmodule

// File: tb/tb_pipeline_flushable.sv
// Randomized and directed bench for pipeline_flushable (NumStages=3 and 0)
// against a per-stage 2-deep queue model.
module tb_pipeline_flushable;

  localparam int NS  = 3;
  localparam int EW  = 8;
  localparam int CW  = pipeline_flushable_pkg::count_width(NS);
  localparam int CW0 = pipeline_flushable_pkg::count_width(0);

  logic          clk;
  logic          arst_n;
  logic          flush;
  logic [EW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [EW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] dut_count;

  logic           z_flush;
  logic [EW-1:0]  z_in;
  logic           z_in_valid;
  logic           z_in_ready;
  logic [EW-1:0]  z_out;
  logic           z_out_valid;
  logic           z_out_ready;
  logic [CW0-1:0] z_count;

  pipeline_flushable #(.ElemWidth(EW), .NumStages(NS)) dut (
    .clk_i            (clk),
    .arst_ni          (arst_n),
    .flush_i          (flush),
    .elem_in_i        (in_data),
    .elem_in_valid_i  (in_valid),
    .elem_in_ready_o  (in_ready),
    .elem_out_o       (out_data),
    .elem_out_valid_o (out_valid),
    .elem_out_ready_i (out_ready)
`ifdef PIPELINE_FLUSHABLE_COUNT_EN
    ,
    .count_o          (dut_count)
`endif
  );

  pipeline_flushable #(.ElemWidth(EW), .NumStages(0)) dut_zero (
    .clk_i            (clk),
    .arst_ni          (arst_n),
    .flush_i          (z_flush),
    .elem_in_i        (z_in),
    .elem_in_valid_i  (z_in_valid),
    .elem_in_ready_o  (z_in_ready),
    .elem_out_o       (z_out),
    .elem_out_valid_o (z_out_valid),
    .elem_out_ready_i (z_out_ready)
`ifdef PIPELINE_FLUSHABLE_COUNT_EN
    ,
    .count_o          (z_count)
`endif
  );

`ifndef PIPELINE_FLUSHABLE_COUNT_EN
  assign dut_count = '0;
  assign z_count   = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: each stage is a bounded FIFO of depth 2.
  logic [EW-1:0] m_data [NS][2];
  int            m_cnt  [NS];
  logic          last_acc;

  logic          obs_valid;
  logic          obs_ready;
  logic [EW-1:0] obs_data;
  logic [EW-1:0] out_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NS; k++) m_cnt[k] = 0;
  endtask

  function automatic int model_total();
    int s = 0;
    for (int k = 0; k < NS; k++) s += m_cnt[k];
    return s;
  endfunction

  task automatic model_update(input logic v, input logic [EW-1:0] d, input logic ordy, input logic fl);
    logic          push [NS+1];
    logic [EW-1:0] pd   [NS];
    if (fl) begin
      model_clear();
    end else begin
      push[0] = v && (m_cnt[0] < 2);
      pd[0]   = d;
      for (int k = 1; k < NS; k++) begin
        push[k] = (m_cnt[k-1] > 0) && (m_cnt[k] < 2);
        pd[k]   = m_data[k-1][0];
      end
      push[NS] = (m_cnt[NS-1] > 0) && ordy;
      for (int k = 0; k < NS; k++) begin
        if (push[k+1]) begin
          m_data[k][0] = m_data[k][1];
          m_cnt[k]--;
        end
        if (push[k]) begin
          m_data[k][m_cnt[k]] = pd[k];
          m_cnt[k]++;
        end
      end
    end
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic cycle(input logic v, input logic [EW-1:0] d, input logic ordy, input logic fl);
    logic exp_valid;
    logic exp_ready;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    exp_valid = (m_cnt[NS-1] > 0) && !fl;
    exp_ready = (m_cnt[0] < 2) || fl;
    obs_valid = out_valid;
    obs_ready = in_ready;
    obs_data  = out_data;
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    if (exp_valid) check("out_data", 32'(out_data), 32'(m_data[NS-1][0]));
`ifdef PIPELINE_FLUSHABLE_COUNT_EN
    check("count", 32'(dut_count), model_total());
`endif
    if (out_valid && ordy) out_log.push_back(out_data);
    last_acc = v && (m_cnt[0] < 2) && !fl;
    model_update(v, d, ordy, fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int            first_out;
    int            last_out;
    int            low_ready;
    int            n_acc;
    logic          rv;
    logic [EW-1:0] rd;
    logic          hold;

    arst_n = 1'b0;
    flush = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    z_flush = 1'b0; z_in = '0; z_in_valid = 1'b0; z_out_ready = 1'b0;
    model_clear();
    #3;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_data", 32'(out_data), 0);
    check("rst_count", 32'(dut_count), 0);
    #9 arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Throughput: 16-element stream with the sink always ready.
    out_log.delete();
    first_out = -1; last_out = -1; low_ready = 0;
    for (int i = 0; i < 22; i++) begin
      cycle(i < 16, EW'(i + 1), 1'b1, 1'b0);
      if (i < 16 && !obs_ready) low_ready++;
      if (obs_valid && first_out < 0) first_out = i;
      if (obs_valid) last_out = i;
    end
    check("thru_first_out", first_out, NS);
    check("thru_last_out", last_out, NS + 15);
    check("thru_ready_low", low_ready, 0);
    check("thru_size", out_log.size(), 16);
    for (int i = 0; i < 16 && i < out_log.size(); i++) check("thru_order", 32'(out_log[i]), i + 1);

    // Fill under backpressure, then release.
    out_log.delete();
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, EW'(8'hA0 + n_acc), 1'b0, 1'b0);
      if (last_acc) n_acc++;
    end
    check("fill_accepted", n_acc, 2 * NS);
    check("fill_ready_low", 32'(obs_ready), 0);
`ifdef PIPELINE_FLUSHABLE_COUNT_EN
    check("fill_count", 32'(dut_count), 2 * NS);
`endif
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("fill_drain_size", out_log.size(), 2 * NS);
    for (int i = 0; i < 2 * NS && i < out_log.size(); i++) check("fill_order", 32'(out_log[i]), 32'h A0 + i);

    // Random valid/ready until 1000 elements are accepted.
    n_acc = 0; hold = 1'b0; rv = 1'b0; rd = '0;
    for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
      if (!hold) begin
        rv = 1'($urandom_range(0, 1));
        rd = EW'($urandom);
      end
      cycle(rv, rd, 1'($urandom_range(0, 1)), 1'b0);
      hold = rv && !last_acc;
      if (last_acc) n_acc++;
    end
    check("rand_accepted", n_acc, 1000);
    for (int i = 0; i < 4 * NS; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("rand_drained", model_total(), 0);

    // Flush with four held elements and a live input, twice back to back.
    for (int i = 0; i < 4; i++) cycle(1'b1, EW'(8'h10 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b1);
    check("flush_valid", 32'(obs_valid), 0);
    check("flush_ready", 32'(obs_ready), 1);
    cycle(1'b1, 8'h66, 1'b1, 1'b1);
    out_log.delete();
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("post_flush_valid", 32'(obs_valid), 0);
    check("post_flush_ready", 32'(obs_ready), 1);
    check("post_flush_count", 32'(dut_count), 0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < NS + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("flush_out_size", out_log.size(), 1);
    if (out_log.size() > 0) check("flush_out_first", 32'(out_log[0]), 32'h77);

    // Async reset while full.
    for (int i = 0; i < 8; i++) cycle(1'b1, EW'(8'hC0 + i), 1'b0, 1'b0);
    arst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_ready", 32'(in_ready), 1);
    check("arst_count", 32'(dut_count), 0);
    check("arst_data", 32'(out_data), 0);
    #1 arst_n = 1'b1;
    model_clear();
    out_log.delete();
    for (int i = 0; i < 4; i++) cycle(1'b1, EW'(i), 1'b1, 1'b0);
    for (int i = 0; i < NS + 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_size", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) check("post_rst_order", 32'(out_log[i]), i);

    // NumStages = 0 passthrough.
    z_in = 8'h3C; z_in_valid = 1'b1; z_out_ready = 1'b1; z_flush = 1'b0;
    #1;
    check("z_data", 32'(z_out), 32'h3C);
    check("z_valid", 32'(z_out_valid), 1);
    check("z_ready", 32'(z_in_ready), 1);
    check("z_count", 32'(z_count), 0);
    z_out_ready = 1'b0;
    #1;
    check("z_ready_bp", 32'(z_in_ready), 0);
    z_flush = 1'b1;
    #1;
    check("z_flush_valid", 32'(z_out_valid), 0);
    check("z_flush_ready", 32'(z_in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
